// File: rtl/memory_bus_arbiter.sv
// Two-to-one arbiter sharing one Wishbone-style bus between the instruction and data ports,
// with alternating priority on contention and a per-cycle timeout that returns an error ack.
//
// state      | meaning
// IDLE       | no bus cycle; choose the next port
// GRANT_INST | bus cycle running for the instruction port
// GRANT_DATA | bus cycle running for the data port
module memory_bus_arbiter #(
    parameter int Width         = 32,
    parameter int AddrWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_inst_mem_en,
    input  logic [AddrWidth-1:0]   i_inst_mem_addr,
    output logic                   o_inst_mem_ack,
    output logic                   o_inst_mem_err,
    output logic [Width-1:0]       o_inst_mem_rd_dat,
    input  logic                   i_data_mem_en,
    input  logic                   i_data_mem_we,
    input  logic [AddrWidth-1:0]   i_data_mem_addr,
    input  logic [Width/8-1:0]     i_data_mem_sel,
    input  logic [Width-1:0]       i_data_mem_wr_dat,
    output logic                   o_data_mem_ack,
    output logic                   o_data_mem_err,
    output logic [Width-1:0]       o_data_mem_rd_dat,
    output logic                   o_mem_cyc,
    output logic                   o_mem_stb,
    output logic                   o_mem_we,
    output logic [AddrWidth-1:0]   o_mem_addr,
    output logic [Width/8-1:0]     o_mem_sel,
    output logic [Width-1:0]       o_mem_wr_dat,
    input  logic                   i_mem_ack,
    input  logic [Width-1:0]       i_mem_rd_dat
);

    localparam int TimerWidth = $clog2(TimeoutCycles + 1);
    localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_INST = 2'd1,
        GRANT_DATA = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_last_data;
    logic [TimerWidth-1:0]   r_timer;
    logic                    r_we;
    logic [AddrWidth-1:0]    r_addr;
    logic [Width/8-1:0]      r_sel;
    logic [Width-1:0]        r_wr_dat;

    logic w_take_inst;
    logic w_take_data;
    logic w_busy;
    logic w_inst_grant;
    logic w_data_grant;
    logic w_timeout;
    logic w_done;

    // Outputs are qualified by i_reset so nothing leaks out while reset is held.
    assign w_busy       = i_reset && (r_state != IDLE);
    assign w_inst_grant = i_reset && (r_state == GRANT_INST);
    assign w_data_grant = i_reset && (r_state == GRANT_DATA);
    assign w_timeout    = w_busy && !i_mem_ack && (r_timer == TimerLast);
    assign w_done       = w_busy && (i_mem_ack || w_timeout);

    always_comb begin
        w_state_next = r_state;
        w_take_inst  = 1'b0;
        w_take_data  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_data_mem_en && (!i_inst_mem_en || !r_last_data)) begin
                    w_take_data  = 1'b1;
                    w_state_next = GRANT_DATA;
                end else if (i_inst_mem_en) begin
                    w_take_inst  = 1'b1;
                    w_state_next = GRANT_INST;
                end
            end
            GRANT_INST, GRANT_DATA: begin
                if (w_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_last_data <= 1'b0;
            r_timer     <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_sel       <= '0;
            r_wr_dat    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_take_inst) begin
                r_we        <= 1'b0;
                r_addr      <= i_inst_mem_addr;
                r_sel       <= '1;
                r_wr_dat    <= '0;
                r_last_data <= 1'b0;
                r_timer     <= '0;
            end else if (w_take_data) begin
                r_we        <= i_data_mem_we;
                r_addr      <= i_data_mem_addr;
                r_sel       <= i_data_mem_sel;
                r_wr_dat    <= i_data_mem_wr_dat;
                r_last_data <= 1'b1;
                r_timer     <= '0;
            end else if (w_busy && !w_done) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign o_inst_mem_ack    = w_inst_grant && w_done;
    assign o_inst_mem_err    = w_inst_grant && w_timeout;
    assign o_inst_mem_rd_dat = (w_inst_grant && i_mem_ack) ? i_mem_rd_dat : '0;

    assign o_data_mem_ack    = w_data_grant && w_done;
    assign o_data_mem_err    = w_data_grant && w_timeout;
    assign o_data_mem_rd_dat = (w_data_grant && i_mem_ack) ? i_mem_rd_dat : '0;

    assign o_mem_cyc    = w_busy;
    assign o_mem_stb    = w_busy;
    assign o_mem_we     = w_busy && r_we;
    assign o_mem_addr   = w_busy ? r_addr   : '0;
    assign o_mem_sel    = w_busy ? r_sel    : '0;
    assign o_mem_wr_dat = w_busy ? r_wr_dat : '0;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: directed scenarios with literal expectations plus random
// request/slave traffic, all outputs compared every cycle against a transaction-level model.
module tb_memory_bus_arbiter;

    localparam int W  = 32;
    localparam int AW = 32;
    localparam int SW = W / 8;
    localparam int TO = 4;

    localparam int SL_NEVER  = 0;
    localparam int SL_DELAY  = 1;
    localparam int SL_RAND   = 2;
    localparam int SL_MANUAL = 3;

    logic          clk;
    logic          rst_n;
    logic          inst_en;
    logic [AW-1:0] inst_addr;
    logic          data_en;
    logic          data_we;
    logic [AW-1:0] data_addr;
    logic [SW-1:0] data_sel;
    logic [W-1:0]  data_wdat;
    logic          mem_ack;
    logic [W-1:0]  mem_rdat;

    logic          inst_ack, inst_err, data_ack, data_err;
    logic [W-1:0]  inst_rd, data_rd;
    logic          mem_cyc, mem_stb, mem_we;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_sel;
    logic [W-1:0]  mem_wdat;

    memory_bus_arbiter #(.Width(W), .AddrWidth(AW), .TimeoutCycles(TO)) dut (
        .i_clock          (clk),
        .i_reset          (rst_n),
        .i_inst_mem_en    (inst_en),
        .i_inst_mem_addr  (inst_addr),
        .o_inst_mem_ack   (inst_ack),
        .o_inst_mem_err   (inst_err),
        .o_inst_mem_rd_dat(inst_rd),
        .i_data_mem_en    (data_en),
        .i_data_mem_we    (data_we),
        .i_data_mem_addr  (data_addr),
        .i_data_mem_sel   (data_sel),
        .i_data_mem_wr_dat(data_wdat),
        .o_data_mem_ack   (data_ack),
        .o_data_mem_err   (data_err),
        .o_data_mem_rd_dat(data_rd),
        .o_mem_cyc        (mem_cyc),
        .o_mem_stb        (mem_stb),
        .o_mem_we         (mem_we),
        .o_mem_addr       (mem_addr),
        .o_mem_sel        (mem_sel),
        .o_mem_wr_dat     (mem_wdat),
        .i_mem_ack        (mem_ack),
        .i_mem_rd_dat     (mem_rdat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Slave: answers bus cycles after a programmable number of wait cycles, never, randomly, or by hand.
    int          slave_mode  = SL_MANUAL;
    int          slave_delay = 0;
    logic        manual_ack  = 1'b0;
    logic [W-1:0] rdat_val   = '0;
    int          cyc_cnt     = 0;

    initial begin
        mem_ack  = 1'b0;
        mem_rdat = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_cyc) cyc_cnt++;
            else cyc_cnt = 0;
            case (slave_mode)
                SL_DELAY: mem_ack = mem_cyc && (cyc_cnt == slave_delay + 1);
                SL_RAND:  mem_ack = mem_cyc ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
                SL_MANUAL: mem_ack = manual_ack;
                default:  mem_ack = 1'b0;
            endcase
            mem_rdat = (slave_mode == SL_RAND) ? W'($urandom) : rdat_val;
        end
    end

    // Transaction-level reference: who owns the bus, how long it has owned it, what it asked for.
    int           m_owner = 0;
    int           m_age   = 0;
    logic         m_inst_turn = 1'b0;
    logic         m_we   = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [SW-1:0] m_sel  = '0;
    logic [W-1:0]  m_wdat = '0;

    logic          e_active, e_expire, e_fin, e_iack, e_dack;
    logic [W-1:0]  e_ird, e_drd;
    logic [70:0]   e_bus;
    logic          seen_iack = 1'b0;
    logic          seen_dack = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            e_active = rst_n && (m_owner != 0);
            e_expire = e_active && !mem_ack && (m_age == TO - 1);
            e_fin    = e_active && (mem_ack || e_expire);
            e_iack   = e_fin && (m_owner == 1);
            e_dack   = e_fin && (m_owner == 2);
            e_ird    = (e_iack && mem_ack) ? mem_rdat : '0;
            e_drd    = (e_dack && mem_ack) ? mem_rdat : '0;
            e_bus    = e_active ? {1'b1, 1'b1, m_we, m_addr, m_sel, m_wdat} : '0;
            chk("inst_port", {inst_ack, inst_err, inst_rd}, {e_iack, e_iack && e_expire, e_ird});
            chk("data_port", {data_ack, data_err, data_rd}, {e_dack, e_dack && e_expire, e_drd});
            chk("bus", {mem_cyc, mem_stb, mem_we, mem_addr, mem_sel, mem_wdat}, e_bus);
            chk("one_ack", inst_ack & data_ack, 1'b0);
            chk("stb_eq_cyc", mem_stb, mem_cyc);
            seen_iack = inst_ack;
            seen_dack = data_ack;

            if (!rst_n) begin
                m_owner = 0; m_age = 0; m_inst_turn = 1'b0;
                m_we = 1'b0; m_addr = '0; m_sel = '0; m_wdat = '0;
            end else if (m_owner == 0) begin
                if (inst_en && data_en) m_owner = m_inst_turn ? 1 : 2;
                else if (data_en)       m_owner = 2;
                else if (inst_en)       m_owner = 1;
                if (m_owner == 1) begin
                    m_we = 1'b0; m_addr = inst_addr; m_sel = '1; m_wdat = '0; m_inst_turn = 1'b0;
                end else if (m_owner == 2) begin
                    m_we = data_we; m_addr = data_addr; m_sel = data_sel; m_wdat = data_wdat;
                    m_inst_turn = 1'b1;
                end
                m_age = 0;
            end else if (e_fin) begin
                m_owner = 0;
            end else begin
                m_age++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; inst_en = 1'b0; data_en = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    int k;
    int ncyc;
    logic [7:0] ord;
    int iwait, dwait;

    initial begin
        rst_n = 1'b0; inst_en = 1'b1; data_en = 1'b1; inst_addr = 32'h44; data_we = 1'b1;
        data_addr = 32'h88; data_sel = 4'hF; data_wdat = 32'h1234; manual_ack = 1'b1;

        // reset holds every output low even with requests and a slave ack present
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {inst_ack, inst_err, inst_rd, data_ack, data_err, data_rd,
                              mem_cyc, mem_stb, mem_we, mem_addr, mem_sel, mem_wdat}, '0);
        step();
        inst_en = 1'b0; data_en = 1'b0; manual_ack = 1'b0; rst_n = 1'b1;

        // instruction fetch, slave answers one cycle after cyc
        step();
        slave_mode = SL_DELAY; slave_delay = 1; rdat_val = 32'h0050_0093;
        inst_en = 1'b1; inst_addr = 32'h100;
        k = 0;
        do begin
            @(posedge clk); k++; @(negedge clk);
        end while (!inst_ack && k < 10);
        chk("t1_latency", k, 2);
        chk("t1_rd_dat", inst_rd, 32'h0050_0093);
        chk("t1_bus", {mem_we, mem_sel, mem_addr}, {1'b0, 4'hF, 32'h100});
        step();
        inst_en = 1'b0;

        // contention from reset: data first, then alternate while both stay requested
        step();
        do_reset();
        slave_mode = SL_DELAY; slave_delay = 0;
        inst_en = 1'b1; data_en = 1'b1; inst_addr = 32'h300; data_we = 1'b0; data_addr = 32'h400;
        ord = '0; k = 0; ncyc = 0;
        while (ncyc < 4 && k < 40) begin
            @(negedge clk); k++;
            if (data_ack) begin ord = {ord[5:0], 2'b10}; ncyc++; end
            if (inst_ack) begin ord = {ord[5:0], 2'b01}; ncyc++; end
        end
        chk("t2_order", ord, 8'b10_01_10_01);
        step();
        inst_en = 1'b0; data_en = 1'b0;

        // data write: bus fields hold while the requester's inputs wander
        step();
        slave_mode = SL_DELAY; slave_delay = 3;
        data_en = 1'b1; data_we = 1'b1; data_addr = 32'h200; data_sel = 4'b0011; data_wdat = 32'hDEAD_BEEF;
        ncyc = 0; k = 0;
        do begin
            step(); k++;
            data_we = ~data_we; data_addr = $urandom; data_sel = 4'($urandom); data_wdat = $urandom;
            @(negedge clk);
            if (mem_cyc) begin
                ncyc++;
                chk("t3_bus_hold", {mem_we, mem_addr, mem_sel, mem_wdat},
                    {1'b1, 32'h200, 4'b0011, 32'hDEAD_BEEF});
            end
        end while (!data_ack && k < 20);
        chk("t3_grant_cycles", ncyc, 4);
        chk("t3_no_err", data_err, 1'b0);
        step();
        data_en = 1'b0;

        // hung slave: error ack on the fourth grant cycle, bus released next cycle
        step();
        slave_mode = SL_NEVER;
        data_en = 1'b1; data_we = 1'b0; data_addr = 32'h500;
        ncyc = 0; k = 0;
        do begin
            @(negedge clk); k++;
            if (mem_cyc) ncyc++;
        end while (!data_ack && k < 20);
        chk("t4_timeout_cycle", ncyc, 4);
        chk("t4_err", {data_ack, data_err, data_rd}, {1'b1, 1'b1, 32'h0});
        step();
        data_en = 1'b0;
        @(negedge clk);
        chk("t4_cyc_drop", mem_cyc, 1'b0);

        // reset mid-grant aborts without ack; a stray ack in Idle is ignored
        step();
        inst_en = 1'b1; inst_addr = 32'h600;
        step();
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_reset_mid", {mem_cyc, inst_ack, data_ack}, 3'b000);
        step();
        rst_n = 1'b1; inst_en = 1'b0; slave_mode = SL_MANUAL; manual_ack = 1'b1;
        @(negedge clk);
        chk("t5_stray_ack", {mem_ack, mem_cyc, inst_ack, data_ack}, 4'b1000);
        step();
        manual_ack = 1'b0;

        // random traffic
        slave_mode = SL_RAND;
        iwait = 0; dwait = 0;
        repeat (2000) begin
            step();
            inst_addr = $urandom; data_addr = $urandom; data_we = 1'($urandom_range(1));
            data_sel = 4'($urandom); data_wdat = $urandom;
            if (inst_en && seen_iack) begin
                chk("inst_wait", iwait <= 16, 1'b1);
                inst_en = 1'($urandom_range(1)); iwait = 0;
            end else if (inst_en && iwait > 16) begin
                chk("inst_starved", iwait, 16);
                inst_en = 1'b0; iwait = 0;
            end else if (inst_en && $urandom_range(31) == 0) begin
                inst_en = 1'b0; iwait = 0;
            end else if (!inst_en) begin
                inst_en = 1'($urandom_range(1)); iwait = 0;
            end else begin
                iwait++;
            end
            if (data_en && seen_dack) begin
                chk("data_wait", dwait <= 16, 1'b1);
                data_en = 1'($urandom_range(1)); dwait = 0;
            end else if (data_en && dwait > 16) begin
                chk("data_starved", dwait, 16);
                data_en = 1'b0; dwait = 0;
            end else if (data_en && $urandom_range(31) == 0) begin
                data_en = 1'b0; dwait = 0;
            end else if (!data_en) begin
                data_en = 1'($urandom_range(1)); dwait = 0;
            end else begin
                dwait++;
            end
        end

        // let outstanding requests finish
        k = 0;
        while ((inst_en || data_en) && k < 40) begin
            step(); k++;
            if (seen_iack) inst_en = 1'b0;
            if (seen_dack) data_en = 1'b0;
        end
        chk("drained", {inst_en, data_en}, 2'b00);
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
